// File: rtl/hybrid_pkg.sv
// hybrid_pkg: shared constants and helpers for the hybrid datapath.
//   - clog2()      : ceiling log2, constant-evaluable
//   - acc_width()  : accumulator width for a window of WIN samples
//   - cnt_width()  : beat-counter width (at least 1 bit)
//   - Def*         : default fixed-point formats and sizes
package hybrid_pkg;

   localparam int unsigned DefWIn  = 8;
   localparam int unsigned DefInI  = 3;
   localparam int unsigned DefWOut = 9;
   localparam int unsigned DefOutI = 4;
   localparam int unsigned DefCh   = 2;
   localparam int unsigned DefWin  = 4;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'(1) << i) < 64'(n)) r = i + 1;
      end
      return r;
   endfunction

   // Sum of WIN signed W_IN-bit samples always fits in this width.
   function automatic int unsigned acc_width(input int unsigned w_in, input int unsigned win);
      return w_in + clog2(win);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned win);
      return (clog2(win) > 0) ? clog2(win) : 1;
   endfunction

endpackage

// File: rtl/hybrid_accum_if.sv
// hybrid_accum_if: input-beat and result-beat handshakes of hybrid_accum.
//   in_valid/in_ready/in_data     : CH samples of W_IN bits, channel c at [c*W_IN +: W_IN]
//   out_valid/out_ready/out_data  : CH results of W_OUT bits, channel c at [c*W_OUT +: W_OUT]
//   sat                           : per-channel saturation flag, qualified by out_valid
// Modports: master drives beats and accepts results; slave is the accumulator.
interface hybrid_accum_if
   import hybrid_pkg::*;
#(
   parameter int unsigned CH    = DefCh,
   parameter int unsigned W_IN  = DefWIn,
   parameter int unsigned W_OUT = DefWOut
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CH*W_IN-1:0]    in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [CH*W_OUT-1:0]   out_data;
   logic [CH-1:0]         sat;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, sat
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, sat
   );
endinterface

// File: rtl/hybrid_fx_conv.sv
// hybrid_fx_conv: combinational requantiser for one channel.
// Converts a signed W_ACC-bit value with FI fractional bits to W_OUT bits with FO
// fractional bits: left shift when FO >= FI, otherwise round half up and shift right.
// Range limiting depends on macro HYBRID_ACCUM_SAT_EN:
//   defined   : clamp to the signed W_OUT range, o_sat = 1 when clamped
//   undefined : wrap to the low W_OUT bits, o_sat = 0
// Ports:
//   i_acc  in  W_ACC  signed accumulator value
//   o_res  out W_OUT  requantised result
//   o_sat  out 1      saturation flag
module hybrid_fx_conv #(
   parameter int unsigned W_ACC = 10,
   parameter int unsigned FI    = 5,
   parameter int unsigned W_OUT = 9,
   parameter int unsigned FO    = 5
) (
   input  logic signed [W_ACC-1:0] i_acc,
   output logic        [W_OUT-1:0] o_res,
   output logic                    o_sat
);

   localparam int unsigned Shl   = (FO >= FI) ? FO - FI : 0;
   localparam int unsigned Shr   = (FI > FO) ? FI - FO : 0;
   localparam int unsigned WBase = (W_ACC + Shl > W_OUT) ? W_ACC + Shl : W_OUT;
   // One guard bit keeps the rounding add and the range compare exact.
   localparam int unsigned WExt  = WBase + 1;

   logic signed [WExt-1:0] w_ext;
   logic signed [WExt-1:0] w_scl;

   assign w_ext = WExt'(i_acc);

   generate
      if (Shr > 0) begin : g_rnd
         logic signed [WExt-1:0] w_rnd;
         assign w_rnd = w_ext + WExt'(1 << (Shr - 1));
         assign w_scl = w_rnd >>> Shr;
      end else begin : g_shl
         assign w_scl = w_ext <<< Shl;
      end
   endgenerate

`ifdef HYBRID_ACCUM_SAT_EN
   localparam logic signed [WExt-1:0] Max = {{(WExt - W_OUT + 1){1'b0}}, {(W_OUT - 1){1'b1}}};
   localparam logic signed [WExt-1:0] Min = {{(WExt - W_OUT + 1){1'b1}}, {(W_OUT - 1){1'b0}}};

   always_comb begin
      o_res = w_scl[W_OUT-1:0];
      o_sat = 1'b0;
      if (w_scl > Max) begin
         o_res = Max[W_OUT-1:0];
         o_sat = 1'b1;
      end else if (w_scl < Min) begin
         o_res = Min[W_OUT-1:0];
         o_sat = 1'b1;
      end
   end
`else
   assign o_res = w_scl[W_OUT-1:0];
   assign o_sat = 1'b0;

   logic w_unused;
   assign w_unused = ^w_scl[WExt-1:W_OUT];
`endif

endmodule

// File: rtl/hybrid_accum.sv
// hybrid_accum: multi-channel fixed-point window accumulator.
// Sums WIN consecutive accepted beats per channel, requantises each sum from
// Q(IN_I, W_IN-IN_I) to Q(OUT_I, W_OUT-OUT_I) and holds one result beat in an
// output register until the downstream pops it.
// Optional macro HYBRID_ACCUM_SAT_EN: saturate results (sat flags live) instead of wrapping.
// Ports:
//   clock   in  rising-edge clock
//   resetn  in  asynchronous active-low reset
//   clr     in  synchronous clear of the partial window (wins over a same-cycle beat)
//   bus     slave modport of hybrid_accum_if (input beats, result beats, sat flags)
module hybrid_accum
   import hybrid_pkg::*;
#(
   parameter int unsigned W_IN  = DefWIn,
   parameter int unsigned IN_I  = DefInI,
   parameter int unsigned W_OUT = DefWOut,
   parameter int unsigned OUT_I = DefOutI,
   parameter int unsigned CH    = DefCh,
   parameter int unsigned WIN   = DefWin
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          clr,
   hybrid_accum_if.slave bus
);

   localparam int unsigned FI   = W_IN - IN_I;
   localparam int unsigned FO   = W_OUT - OUT_I;
   localparam int unsigned WAcc = acc_width(W_IN, WIN);
   localparam int unsigned CntW = cnt_width(WIN);
   localparam logic [CntW-1:0] CntLast = CntW'(WIN - 1);

   logic signed [WAcc-1:0]  r_acc [CH];
   logic        [CntW-1:0]  r_cnt;
   logic                    r_out_valid;
   logic [CH*W_OUT-1:0]     r_out;
   logic [CH-1:0]           r_sat;

   logic signed [WAcc-1:0]  w_sum [CH];
   logic [CH*W_OUT-1:0]     w_res;
   logic [CH-1:0]           w_sat;
   logic                    w_last;
   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_load;
   logic                    w_pop;

   assign w_last     = (r_cnt == CntLast);
   // Only the final beat of a window needs space in the output register.
   assign w_in_ready = !w_last || !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_load     = w_accept && w_last && !clr;
   assign w_pop      = r_out_valid && bus.out_ready;

   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         logic signed [W_IN-1:0] w_smp;
         assign w_smp    = bus.in_data[c*W_IN +: W_IN];
         assign w_sum[c] = r_acc[c] + WAcc'(w_smp);

         hybrid_fx_conv #(
            .W_ACC (WAcc),
            .FI    (FI),
            .W_OUT (W_OUT),
            .FO    (FO)
         ) u_conv (
            .i_acc (w_sum[c]),
            .o_res (w_res[c*W_OUT +: W_OUT]),
            .o_sat (w_sat[c])
         );
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int c = 0; c < CH; c++) r_acc[c] <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out       <= '0;
         r_sat       <= '0;
      end else begin
         if (clr) begin
            for (int c = 0; c < CH; c++) r_acc[c] <= '0;
            r_cnt <= '0;
         end else if (w_accept) begin
            if (w_last) begin
               for (int c = 0; c < CH; c++) r_acc[c] <= '0;
               r_cnt <= '0;
            end else begin
               for (int c = 0; c < CH; c++) r_acc[c] <= w_sum[c];
               r_cnt <= r_cnt + CntW'(1);
            end
         end

         // A load in the same cycle as a pop keeps out_valid high.
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out       <= w_res;
            r_sat       <= w_sat;
         end else if (w_pop) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out;
   assign bus.sat       = r_sat;

endmodule

// File: tb/tb_hybrid_accum.sv
// tb_hybrid_accum: directed self-checking bench for hybrid_accum.
// dut  : default formats, WIN = 4 (FI = FO = 5)
// dut1 : WIN = 1, OUT_I = 6 (FO = 3), exercising round-half-up requantisation
// Expectations follow HYBRID_ACCUM_SAT_EN when it is defined for the build.
module tb_hybrid_accum;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   logic clr    = 1'b0;
   logic clr1   = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   hybrid_accum_if #(.CH(2), .W_IN(8), .W_OUT(9)) bus ();
   hybrid_accum_if #(.CH(2), .W_IN(8), .W_OUT(9)) bus1 ();

   hybrid_accum #(
      .W_IN(8), .IN_I(3), .W_OUT(9), .OUT_I(4), .CH(2), .WIN(4)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .clr    (clr),
      .bus    (bus)
   );

   hybrid_accum #(
      .W_IN(8), .IN_I(3), .W_OUT(9), .OUT_I(6), .CH(2), .WIN(1)
   ) dut1 (
      .clock  (clock),
      .resetn (resetn),
      .clr    (clr1),
      .bus    (bus1)
   );

   // Present one beat and hold it until accepted (bounded wait).
   task automatic push(input logic [15:0] d);
      int n;
      n = 0;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      while (!bus.in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Let any pending result pop before a test changes out_ready.
   task automatic drain();
      @(negedge clock);
      bus.out_ready = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus1.in_valid  = 1'b0;
      bus1.in_data   = '0;
      bus1.out_ready = 1'b1;
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      resetn = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b need 0", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== 18'h0) begin
         errors++; $display("FAIL reset_out: got %h need 00000", bus.out_data);
      end
      checks++;
      if (bus.sat !== 2'b00) begin
         errors++; $display("FAIL reset_sat: got %b need 00", bus.sat);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b need 1", bus.in_ready);
      end
      checks++;
      if (bus1.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid_win1: got %b need 0", bus1.out_valid);
      end
   endtask

   task automatic test_sum();
      repeat (3) push(16'h1111);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL sum_midwin_valid: got %b need 0", bus.out_valid);
      end
      push(16'h1111);
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL sum_valid: got %b need 1", bus.out_valid);
      end
      checks++;
      if (bus.out_data !== {9'd68, 9'd68}) begin
         errors++; $display("FAIL sum_out: got %h need %h", bus.out_data, {9'd68, 9'd68});
      end
      checks++;
      if (bus.sat !== 2'b00) begin
         errors++; $display("FAIL sum_sat: got %b need 00", bus.sat);
      end
   endtask

   task automatic test_sat();
      logic [17:0] exp_pos, exp_neg;
      logic [1:0]  exp_s;
`ifdef HYBRID_ACCUM_SAT_EN
      exp_pos = {9'h0FF, 9'h0FF};
      exp_neg = {9'h100, 9'h100};
      exp_s   = 2'b11;
`else
      exp_pos = {9'h1FC, 9'h1FC};
      exp_neg = {9'h000, 9'h000};
      exp_s   = 2'b00;
`endif
      repeat (4) push(16'h7F7F);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_pos) begin
         errors++; $display("FAIL sat_pos_out: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, exp_pos);
      end
      checks++;
      if (bus.sat !== exp_s) begin
         errors++; $display("FAIL sat_pos_flag: got %b need %b", bus.sat, exp_s);
      end
      repeat (4) push(16'h8080);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_neg) begin
         errors++; $display("FAIL sat_neg_out: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, exp_neg);
      end
      checks++;
      if (bus.sat !== exp_s) begin
         errors++; $display("FAIL sat_neg_flag: got %b need %b", bus.sat, exp_s);
      end
   endtask

   task automatic test_backpressure();
      drain();
      bus.out_ready = 1'b0;
      repeat (4) push(16'h0101);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {9'd4, 9'd4}) begin
         errors++; $display("FAIL bp_first: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, {9'd4, 9'd4});
      end
      repeat (3) push(16'h0202);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0202;
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_stall_ready: got %b need 0", bus.in_ready);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== {9'd4, 9'd4}) begin
         errors++; $display("FAIL bp_hold: got rdy=%b v=%b %h need rdy=0 v=1 %h",
                            bus.in_ready, bus.out_valid, bus.out_data, {9'd4, 9'd4});
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_ready: got %b need 1", bus.in_ready);
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {9'd8, 9'd8}) begin
         errors++; $display("FAIL bp_second: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, {9'd8, 9'd8});
      end
      @(posedge clock);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_popped: got %b need 0", bus.out_valid);
      end
   endtask

   task automatic test_clr();
      @(negedge clock);
      bus.out_ready = 1'b0;
      repeat (4) push(16'h0303);
      repeat (2) push(16'h2020);
      // clr together with a valid beat: the beat is dropped.
      @(negedge clock);
      clr          = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h2020;
      @(posedge clock);
      #1;
      clr          = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {9'd12, 9'd12}) begin
         errors++; $display("FAIL clr_pending_kept: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, {9'd12, 9'd12});
      end
      drain();
      repeat (4) push(16'hFF01);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {9'h1FC, 9'd4}) begin
         errors++; $display("FAIL clr_result: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, {9'h1FC, 9'd4});
      end
   endtask

   task automatic test_reset_mid();
      drain();
      bus.out_ready = 1'b0;
      repeat (4) push(16'h0303);
      repeat (2) push(16'h0505);
      @(negedge clock);
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 18'h0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_state: got v=%b %h rdy=%b need v=0 00000 rdy=1",
                            bus.out_valid, bus.out_data, bus.in_ready);
      end
      @(negedge clock);
      resetn        = 1'b1;
      bus.out_ready = 1'b1;
      repeat (4) push(16'h0101);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== {9'd4, 9'd4}) begin
         errors++; $display("FAIL rstmid_discard: got v=%b %h need v=1 %h",
                            bus.out_valid, bus.out_data, {9'd4, 9'd4});
      end
   endtask

   task automatic test_win1();
      logic [15:0] vin  [5];
      logic [17:0] vexp [5];
      vin  = '{16'hFA06, 16'h0502, 16'h807F, 16'hFE02, 16'h0000};
      vexp = '{{9'h1FF, 9'd2}, {9'd1, 9'd1}, {9'h1E0, 9'd32}, {9'd0, 9'd1}, {9'd0, 9'd0}};
      bus1.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         bus1.in_valid = 1'b1;
         bus1.in_data  = vin[i];
         checks++;
         if (bus1.in_ready !== 1'b1) begin
            errors++; $display("FAIL win1_ready[%0d]: got %b need 1", i, bus1.in_ready);
         end
         @(posedge clock);
         #1;
         checks++;
         if (bus1.out_valid !== 1'b1 || bus1.out_data !== vexp[i] || bus1.sat !== 2'b00) begin
            errors++; $display("FAIL win1_out[%0d]: got v=%b %h sat=%b need v=1 %h sat=00",
                               i, bus1.out_valid, bus1.out_data, bus1.sat, vexp[i]);
         end
      end
      bus1.in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sum();
      test_sat();
      test_backpressure();
      test_clr();
      test_reset_mid();
      test_win1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hybrid_accum.md
# hybrid_accum

Multi-channel fixed-point window accumulator for the hybrid datapath. Accepts CH signed two's-complement samples per beat over a valid/ready handshake. Sums WIN consecutive beats per channel and requantises each sum from the input Q-format to the output Q-format. Emits one result beat per window through a one-deep output register with backpressure.

## Interface
- W_IN, 8, input sample wordlength (signed)
- IN_I, 3, input integer bits incl. sign; input fractional bits FI = W_IN-IN_I
- W_OUT, 9, output wordlength (signed)
- OUT_I, 4, output integer bits incl. sign; output fractional bits FO = W_OUT-OUT_I
- CH, 2, number of independent channels
- WIN, 4, samples per window, >= 1
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the partial window
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in  in  CH*W_IN  channel c at bits [c*W_IN +: W_IN]
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- out  out  CH*W_OUT  channel c at bits [c*W_OUT +: W_OUT]
- sat  out  CH  per-channel saturation flag, qualified by out_valid

## Operation
- Accumulator per channel: W_ACC = W_IN + clog2(WIN) bits, sign-extended adds, never overflows internally.
- Beat counter cnt: 0..WIN-1. Accept with cnt < WIN-1: acc += in, cnt++. Accept with cnt == WIN-1 (the final beat): result = requant(acc + in) loaded into the output register, acc <= 0, cnt <= 0.
- Requant:
  - FO >= FI: shift left by FO-FI.
  - FO < FI: add 2^(FI-FO-1), then shift arithmetic right by FI-FO (round half up).
  - Then range-limit to W_OUT signed (see Configuration).
- in_ready = (cnt != WIN-1) || !out_valid || out_ready. Mid-window beats are always accepted; the final beat waits for output space.
- Output register: out_valid set on final-beat accept. It holds until out_valid && out_ready. Simultaneous pop and final-beat accept: the new result loads and out_valid stays 1.
- clr: acc <= 0 and cnt <= 0. clr has priority over a same-cycle accept, and that beat is dropped. A pending output is unaffected.
- WIN = 1: every accepted beat is a final beat; the block is a registered requantiser.
- Reset: acc = 0, cnt = 0, out_valid = 0, out = 0, sat = 0; in_ready = 1 after reset.

## Timing
- Latency: result visible on out one cycle after the rising edge accepting the final beat.
- Throughput: one beat per cycle while out_ready = 1. One result per WIN beats.
- in_ready depends combinationally on out_ready; no other input-to-output combinational path.
- Reset mid-window discards the partial sums and any pending result.

## Configuration
- HYBRID_ACCUM_SAT_EN defined:
  - A result above 2^(W_OUT-1)-1 clamps to that value; a result below -2^(W_OUT-1) clamps to that value.
  - The channel's sat bit is 1 with that result, else 0.
- HYBRID_ACCUM_SAT_EN undefined:
  - The result wraps to its low W_OUT bits.
  - sat is tied to 0 and no compare logic is built.

## Structure
- Shared package hybrid_pkg holds:
  - the clog2 function;
  - default format constants (W_IN/IN_I/W_OUT/OUT_I defaults);
  - the derived W_ACC expression.
- Sub-module hybrid_fx_conv: combinational requantise plus saturate for one channel, parametrised by W_ACC, FI, W_OUT, FO. It is instantiated CH times.

## Test plan
Defaults (FI = FO = 5, so requant only range-limits):
- Reset, then 4 beats of 8'b000_10001 on both channels with out_ready = 1 -> one cycle after the 4th accept, out_valid = 1, each channel 9'd68 (2.125), sat = 0.
- 4 beats of 8'h7F -> with SAT_EN: 9'h0FF, sat = 1. Without SAT_EN: 9'h1FC, sat = 0.
- 4 beats of 8'h80 -> with SAT_EN: 9'h100, sat = 1.
- out_ready = 0 after the first result:
  - the next 3 beats are accepted;
  - 4th beat: in_ready = 0 until out_ready rises;
  - first result stays stable until popped;
  - the second result follows with no lost beat.
- 2 beats of 8'd32, then clr, then 4 beats of 8'd1 -> result 9'd4 (the cleared partial window is discarded).
- WIN = 1, FO = 3: input 8'b000_00110 (0.1875) -> out 9'd2 after rounding half up. Assert resetn low mid-window -> out_valid = 0 and the partial window is discarded.
